// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one cache interface between instruction fetch and data memory.
// Data port has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    // data port
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    // hazard logic
    output logic              stall_if,
    output logic              stall_mem,
    // cache side
    output logic              c_req,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_wdata,
    input  logic [DATA_W-1:0] c_rdata,
    input  logic              c_ack,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, RESP} state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e            state_q, state_d;
    logic              owner_mem_q, owner_mem_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              c_we_q, c_we_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic [DATA_W-1:0] c_wdata_q, c_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic grant_if;
    logic grant_mem;

    // Fetch only beats a competing data request once it has been starved long enough.
    assign grant_if  = (state_q == IDLE) && if_req && (!mem_req || (starve_cnt_q == LIMIT));
    assign grant_mem = (state_q == IDLE) && mem_req && !grant_if;

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_mem_q  <= 1'b0;
            starve_cnt_q <= 4'd0;
            c_we_q       <= 1'b0;
            c_addr_q     <= '0;
            c_wdata_q    <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_mem_q  <= owner_mem_d;
            starve_cnt_q <= starve_cnt_d;
            c_we_q       <= c_we_d;
            c_addr_q     <= c_addr_d;
            c_wdata_q    <= c_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    // Next-state logic
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        unique case (state_q)
            IDLE: begin
                if (grant_if)       state_d = BUS_IF;
                else if (grant_mem) state_d = BUS_MEM;
            end
            BUS_IF: begin
                if (c_ack) begin
                    state_d     = RESP;
                    owner_mem_d = 1'b0;
                end
            end
            BUS_MEM: begin
                if (c_ack) begin
                    state_d     = RESP;
                    owner_mem_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: request capture at grant, read data capture at ack, starvation tracking
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        c_we_d       = c_we_q;
        c_addr_d     = c_addr_q;
        c_wdata_d    = c_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;

        if (grant_if) begin
            c_addr_d     = if_addr;
            c_we_d       = 1'b0;
            starve_cnt_d = 4'd0;
        end else if (grant_mem) begin
            c_addr_d  = mem_addr;
            c_we_d    = mem_we;
            c_wdata_d = mem_wdata;
            if (if_req && (starve_cnt_q < LIMIT)) starve_cnt_d = starve_cnt_q + 4'd1;
        end

        if ((state_q == BUS_IF) && c_ack)            if_rdata_d  = c_rdata;
        if ((state_q == BUS_MEM) && c_ack && !c_we_q) mem_rdata_d = c_rdata;
    end

    // Output logic
    always_comb begin
        c_req     = (state_q == BUS_IF) || (state_q == BUS_MEM);
        busy      = (state_q != IDLE);
        if_ready  = (state_q == RESP) && !owner_mem_q;
        mem_ready = (state_q == RESP) && owner_mem_q;
        stall_if  = if_req & ~if_ready;
        stall_mem = mem_req & ~mem_ready;
        c_we      = c_we_q;
        c_addr    = c_addr_q;
        c_wdata   = c_wdata_q;
        if_rdata  = if_rdata_q;
        mem_rdata = mem_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset, fetch, load/store, arbitration.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;
    logic        c_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
        mem_addr = 0; mem_wdata = 0; c_rdata = 0; c_ack = 0;
        repeat (2) tick;
        checks++;
        if ({c_req, c_we, busy, if_ready, mem_ready, stall_if, stall_mem} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0", {c_req, c_we, busy, if_ready, mem_ready, stall_if, stall_mem});
        end
        checks++;
        if ({c_addr, c_wdata, if_rdata, mem_rdata} !== 128'b0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {c_addr, c_wdata, if_rdata, mem_rdata});
        end
        rst = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0 || c_req !== 1'b0) begin
            errors++; $display("FAIL reset_idle busy %b c_req %b exp 0 0", busy, c_req);
        end
    endtask

    task automatic test_fetch;
        if_req = 1; if_addr = 32'h0000_0040;
        #1;
        checks++;
        if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall got %b exp 1", stall_if); end
        for (int i = 0; i < 3; i++) begin
            tick;
            if (i == 2) begin c_ack = 1; c_rdata = 32'h0051_0093; end
            checks++;
            if (c_req !== 1'b1 || c_addr !== 32'h40 || c_we !== 1'b0) begin
                errors++; $display("FAIL fetch_bus%0d c_req %b c_addr %h c_we %b exp 1 40 0", i, c_req, c_addr, c_we);
            end
            checks++;
            if (if_ready !== 1'b0) begin errors++; $display("FAIL fetch_early_ready%0d got %b exp 0", i, if_ready); end
        end
        tick;
        c_ack = 0;
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h0051_0093 || mem_ready !== 1'b0) begin
            errors++; $display("FAIL fetch_resp if_ready %b if_rdata %h mem_ready %b exp 1 00510093 0", if_ready, if_rdata, mem_ready);
        end
        checks++;
        if (c_req !== 1'b0 || stall_if !== 1'b0) begin
            errors++; $display("FAIL fetch_resp_bus c_req %b stall_if %b exp 0 0", c_req, stall_if);
        end
        if_req = 0;
        tick;
        checks++;
        if (if_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL fetch_done if_ready %b busy %b exp 0 0", if_ready, busy);
        end
    endtask

    task automatic test_stray_ack_load;
        c_ack = 1; c_rdata = 32'h0000_0BAD;
        tick;
        c_ack = 0;
        checks++;
        if (if_ready !== 1'b0 || mem_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stray_ack if_ready %b mem_ready %b busy %b exp 0 0 0", if_ready, mem_ready, busy);
        end
        mem_req = 1; mem_we = 0; mem_addr = 32'h200;
        tick;
        checks++;
        if (c_req !== 1'b1 || c_addr !== 32'h200 || c_we !== 1'b0) begin
            errors++; $display("FAIL load_bus c_req %b c_addr %h c_we %b exp 1 200 0", c_req, c_addr, c_we);
        end
        c_ack = 1; c_rdata = 32'h1234_5678;
        tick;
        c_ack = 0;
        checks++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'h1234_5678 || if_ready !== 1'b0) begin
            errors++; $display("FAIL load_resp mem_ready %b mem_rdata %h if_ready %b exp 1 12345678 0", mem_ready, mem_rdata, if_ready);
        end
        mem_req = 0;
        tick;
        checks++;
        if (mem_ready !== 1'b0) begin errors++; $display("FAIL load_done mem_ready %b exp 0", mem_ready); end
    endtask

    task automatic test_store;
        mem_req = 1; mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
        tick;
        checks++;
        if (c_req !== 1'b1 || c_we !== 1'b1 || c_wdata !== 32'hDEAD_BEEF || c_addr !== 32'h100) begin
            errors++; $display("FAIL store_bus c_req %b c_we %b c_wdata %h c_addr %h exp 1 1 deadbeef 100", c_req, c_we, c_wdata, c_addr);
        end
        c_ack = 1; c_rdata = 32'h5555_AAAA;
        tick;
        c_ack = 0;
        checks++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'h1234_5678 || stall_mem !== 1'b0) begin
            errors++; $display("FAIL store_resp mem_ready %b mem_rdata %h stall_mem %b exp 1 12345678 0", mem_ready, mem_rdata, stall_mem);
        end
        mem_req = 0; mem_we = 0;
        tick;
    endtask

    task automatic test_starvation;
        logic [7:0] exp_if;
        logic [3:0] cnt_before;
        exp_if = 8'b1000_1000;
        if_req = 1; if_addr = 32'h1000;
        mem_req = 1; mem_we = 0; mem_addr = 32'h2000;
        for (int i = 0; i < 8; i++) begin
            cnt_before = dut.starve_cnt_q;
            tick;
            checks++;
            if (c_addr !== (exp_if[i] ? 32'h1000 : 32'h2000)) begin
                errors++; $display("FAIL starve_grant%0d c_addr %h exp %h", i, c_addr, exp_if[i] ? 32'h1000 : 32'h2000);
            end
            if (exp_if[i]) begin
                checks++;
                if (cnt_before !== 4'd3) begin errors++; $display("FAIL starve_cnt%0d got %0d exp 3", i, cnt_before); end
            end
            c_ack = 1; c_rdata = 32'(i);
            tick;
            c_ack = 0;
            checks++;
            if (if_ready !== exp_if[i] || mem_ready !== !exp_if[i]) begin
                errors++; $display("FAIL starve_ready%0d if_ready %b mem_ready %b exp %b %b", i, if_ready, mem_ready, exp_if[i], !exp_if[i]);
            end
            if (i == 7) begin if_req = 0; mem_req = 0; end
            tick;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL starve_end busy %b exp 0", busy); end
    endtask

    task automatic test_fetch_during_load;
        mem_req = 1; mem_we = 0; mem_addr = 32'h300;
        tick;
        if_req = 1; if_addr = 32'h44;
        #1;
        checks++;
        if (stall_if !== 1'b1 || c_addr !== 32'h300) begin
            errors++; $display("FAIL late_if_bus stall_if %b c_addr %h exp 1 300", stall_if, c_addr);
        end
        tick;
        c_ack = 1; c_rdata = 32'hCAFE_0001;
        tick;
        c_ack = 0;
        checks++;
        if (mem_ready !== 1'b1 || stall_if !== 1'b1 || stall_mem !== 1'b0 || mem_rdata !== 32'hCAFE_0001) begin
            errors++; $display("FAIL late_if_resp mem_ready %b stall_if %b stall_mem %b mem_rdata %h exp 1 1 0 cafe0001", mem_ready, stall_if, stall_mem, mem_rdata);
        end
        mem_req = 0;
        tick;
        checks++;
        if (busy !== 1'b0 || stall_if !== 1'b1) begin
            errors++; $display("FAIL late_if_idle busy %b stall_if %b exp 0 1", busy, stall_if);
        end
        tick;
        checks++;
        if (c_req !== 1'b1 || c_addr !== 32'h44 || c_we !== 1'b0) begin
            errors++; $display("FAIL late_if_grant c_req %b c_addr %h c_we %b exp 1 44 0", c_req, c_addr, c_we);
        end
        c_ack = 1; c_rdata = 32'h0000_0013;
        tick;
        c_ack = 0;
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h13) begin
            errors++; $display("FAIL late_if_resp2 if_ready %b if_rdata %h exp 1 13", if_ready, if_rdata);
        end
        if_req = 0;
        tick;
    endtask

    task automatic test_reset_mid;
        mem_req = 1; mem_we = 1; mem_addr = 32'h400; mem_wdata = 32'h7777_7777;
        tick;
        checks++;
        if (c_req !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre c_req %b busy %b exp 1 1", c_req, busy);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (c_req !== 1'b0 || busy !== 1'b0 || c_addr !== 32'h0 || c_we !== 1'b0) begin
            errors++; $display("FAIL rst_mid c_req %b busy %b c_addr %h c_we %b exp 0 0 0 0", c_req, busy, c_addr, c_we);
        end
        mem_req = 0; mem_we = 0;
        tick;
        rst = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0 || mem_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after busy %b mem_ready %b exp 0 0", busy, mem_ready);
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_stray_ack_load;
        test_store;
        test_starvation;
        test_fetch_during_load;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
